seg_share_ctrl: RTL and testbench

- Time-shares the single 32-bit, 8-digit hex seven-segment display peripheral between 4 independent requesters (for example CPU MMIO, debug unit, trap handler, boot ROM).
- Each requester owns a slot register. The controller rotates round-robin through the occupied slots, showing each for P_DWELL cycles.
- It drives the display peripheral's 32-bit data input and write strobe. Its outputs connect directly to that data/write-enable pair.

---
 rtl/seg_share_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_seg_share_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_share_ctrl.sv
// ---------------------------------------------------------------------------
// seg_share_ctrl
//
// Time-shares one 32-bit, 8-digit hex seven-segment display between four
// requesters. Each requester owns a slot (value + occupied bit). The
// controller rotates round-robin through the occupied slots, holding each on
// the display for P_DWELL cycles, and issues a one-cycle write strobe toward
// the display peripheral whenever the shown value has to change.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   iWr    - per-slot write strobe (bit i loads slot i from iData[i*32+:32])
//   iData  - per-slot write data, 32 bits per slot
//   iRel   - per-slot release strobe (bit i frees slot i; beats iWr[i])
//   oSeg   - registered display data toward the peripheral
//   oWe    - registered one-cycle write strobe toward the peripheral
//   oCur   - index of the slot currently shown
//   oBusy  - 1 while at least one slot is occupied
// ---------------------------------------------------------------------------
module seg_share_ctrl #(
    parameter int          P_NREQ     = 4,
    parameter int          P_DWELL    = 50_000_000,
    parameter logic [31:0] P_IDLE_VAL = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [P_NREQ-1:0]           iWr,
    input  logic [P_NREQ*32-1:0]        iData,
    input  logic [P_NREQ-1:0]           iRel,
    output logic [31:0]                 oSeg,
    output logic                        oWe,
    output logic [$clog2(P_NREQ)-1:0]   oCur,
    output logic                        oBusy
);

    localparam int             IDX_W      = $clog2(P_NREQ);
    localparam int             CNT_W      = $clog2(P_DWELL);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(P_DWELL - 1);

    typedef enum logic {
        S_IDLE,
        S_SHOW
    } state_t;

    // Registered state
    state_t            state;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [P_NREQ-1:0] occ;
    logic [31:0]       val [P_NREQ];
    logic [IDX_W-1:0]  cur;
    logic [31:0]       seg;
    logic              we;
    logic              busy;

    // Next-cycle values
    state_t            state_n;
    logic [CNT_W-1:0]  dwell_cnt_n;
    logic [P_NREQ-1:0] occ_n;
    logic [P_NREQ-1:0] wr_eff;
    logic [31:0]       val_n [P_NREQ];
    logic [IDX_W-1:0]  cur_n;
    logic [31:0]       seg_n;
    logic              we_n;

    // Search helpers
    logic              rot_found;
    logic [IDX_W-1:0]  rot_idx;
    logic              first_found;
    logic [IDX_W-1:0]  first_idx;
    logic              rot_other;
    logic              expire;

    // First occupied slot strictly after 'from', wrapping; 'from' itself is
    // tested last so a lone occupied current slot is still reported.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] find_next(
        input logic [P_NREQ-1:0] occ_v,
        input logic [IDX_W-1:0]  from
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        found = 1'b0;
        pick  = from;
        for (int k = 1; k <= P_NREQ; k++) begin
            idx = from + IDX_W'(k);
            if (!found && occ_v[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    // Storage update: release beats a same-cycle write to the same slot.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_eff = iWr & ~iRel;
        occ_n  = (occ | iWr) & ~iRel;
        for (int i = 0; i < P_NREQ; i++) begin
            val_n[i] = wr_eff[i] ? iData[i*32 +: 32] : val[i];
        end
    end

    // Searches see occupancy after this cycle's writes and releases.
    always_comb begin
        {rot_found, rot_idx}     = find_next(occ_n, cur);
        // Starting after the highest index makes the search begin at slot 0.
        {first_found, first_idx} = find_next(occ_n, IDX_W'(P_NREQ - 1));
        rot_other                = rot_found && (rot_idx != cur);
        expire                   = (dwell_cnt == DWELL_LAST);
    end

    // Next-state and output decode
    always_comb begin
        state_n     = state;
        dwell_cnt_n = dwell_cnt;
        cur_n       = cur;
        seg_n       = seg;
        we_n        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (first_found) begin
                    state_n     = S_SHOW;
                    cur_n       = first_idx;
                    seg_n       = val_n[first_idx];
                    we_n        = 1'b1;
                    dwell_cnt_n = '0;
                end
            end

            S_SHOW: begin
                if (iRel[cur]) begin
                    // Shown slot released: move on, or blank the display.
                    dwell_cnt_n = '0;
                    we_n        = 1'b1;
                    if (rot_found) begin
                        cur_n = rot_idx;
                        seg_n = val_n[rot_idx];
                    end else begin
                        state_n = S_IDLE;
                        seg_n   = P_IDLE_VAL;
                    end
                end else if (expire && rot_other) begin
                    cur_n       = rot_idx;
                    seg_n       = val_n[rot_idx];
                    we_n        = 1'b1;
                    dwell_cnt_n = '0;
                end else begin
                    // Staying on the same slot; a lone slot just restarts its
                    // dwell without re-writing the display.
                    dwell_cnt_n = expire ? '0 : dwell_cnt + CNT_W'(1);
                    if (wr_eff[cur]) begin
                        seg_n = val_n[cur];
                        we_n  = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            occ       <= '0;
            cur       <= '0;
            seg       <= P_IDLE_VAL;
            we        <= 1'b0;
            busy      <= 1'b0;
            // NOTE: the slot values are small flop storage with a defined
            // reset value, so they are cleared with the rest of the state
            // rather than left to power-up contents.
            for (int i = 0; i < P_NREQ; i++) begin
                val[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state     <= state_n;
            dwell_cnt <= dwell_cnt_n;
            occ       <= occ_n;
            cur       <= cur_n;
            seg       <= seg_n;
            we        <= we_n;
            busy      <= |occ_n;
            for (int i = 0; i < P_NREQ; i++) begin
                val[i] <= val_n[i];
            end
        end
    end

    assign oSeg  = seg;
    assign oWe   = we;
    assign oCur  = cur;
    assign oBusy = busy;

endmodule

// File: tb/tb_seg_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_share_ctrl
//
// Self-checking bench for seg_share_ctrl with a short dwell of 4 cycles.
// A vector table covers the basic single-slot, idle and two-slot rotation
// behaviour, hand-written sequences cover release mid-dwell, a write just
// before expiry and asynchronous reset, and a randomized run is compared
// against a behavioural model of the slot/rotation rules.
// ---------------------------------------------------------------------------
module tb_seg_share_ctrl;

    localparam int          DWELL = 4;
    localparam logic [31:0] IDLE  = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   iWr = '0;
    logic [127:0] iData = '0;
    logic [3:0]   iRel = '0;
    logic [31:0]  oSeg;
    logic         oWe;
    logic [1:0]   oCur;
    logic         oBusy;

    seg_share_ctrl #(
        .P_NREQ    (4),
        .P_DWELL   (DWELL),
        .P_IDLE_VAL(IDLE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iWr  (iWr),
        .iData(iData),
        .iRel (iRel),
        .oSeg (oSeg),
        .oWe  (oWe),
        .oCur (oCur),
        .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // {seg, we, cur, busy}
    function automatic logic [35:0] pk(input logic [31:0] s, input logic w,
                                       input logic [1:0] c, input logic b);
        return {s, w, c, b};
    endfunction

    function automatic logic [35:0] outs();
        return {oSeg, oWe, oCur, oBusy};
    endfunction

    function automatic logic [127:0] d(input int slot, input logic [31:0] v);
        logic [127:0] r;
        r = '0;
        r[slot*32 +: 32] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got seg=%h we=%b cur=%0d busy=%b, want seg=%h we=%b cur=%0d busy=%b",
                     name, act[35:4], act[3], act[2:1], act[0],
                     exp[35:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] wr, input logic [127:0] data, input logic [3:0] rel);
        iWr   = wr;
        iData = data;
        iRel  = rel;
        tick();
        iWr  = '0;
        iRel = '0;
    endtask

    task automatic step_chk(input string name, input logic [3:0] wr, input logic [127:0] data,
                            input logic [3:0] rel, input logic [35:0] exp);
        apply(wr, data, rel);
        check(name, outs(), exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: slots, a shown slot, and time spent on it.
    // ------------------------------------------------------------------
    logic [31:0] m_val [4];
    bit          m_occ [4];
    bit          m_show;
    int          m_cur;
    int          m_el;
    logic [31:0] m_seg;
    bit          m_we;
    bit          m_busy;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i] = '0;
            m_occ[i] = 1'b0;
        end
        m_show = 1'b0;
        m_cur  = 0;
        m_el   = 0;
        m_seg  = IDLE;
        m_we   = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_show(input int s);
        m_cur  = s;
        m_seg  = m_val[s];
        m_we   = 1'b1;
        m_el   = 0;
        m_show = 1'b1;
    endtask

    task automatic model_step(input logic [3:0] wr, input logic [127:0] data, input logic [3:0] rel);
        int others[$];
        int n_occ;
        int low;
        for (int i = 0; i < 4; i++) begin
            if (rel[i]) m_occ[i] = 1'b0;
            else if (wr[i]) begin
                m_val[i] = data[i*32 +: 32];
                m_occ[i] = 1'b1;
            end
        end
        n_occ = 0;
        low   = -1;
        for (int i = 3; i >= 0; i--) begin
            if (m_occ[i]) begin
                n_occ++;
                low = i;
            end
        end
        // Other occupied slots in round-robin order after the shown one.
        for (int j = 1; j < 4; j++) begin
            if (m_occ[(m_cur + j) % 4]) others.push_back((m_cur + j) % 4);
        end
        m_we = 1'b0;
        if (!m_show) begin
            if (n_occ > 0) model_show(low);
        end else if (rel[m_cur]) begin
            if (others.size() > 0) model_show(others[0]);
            else begin
                m_seg  = IDLE;
                m_we   = 1'b1;
                m_show = 1'b0;
            end
        end else if (m_el == DWELL - 1 && others.size() > 0) begin
            model_show(others[0]);
        end else begin
            m_el = (m_el == DWELL - 1) ? 0 : m_el + 1;
            if (wr[m_cur]) begin
                m_seg = m_val[m_cur];
                m_we  = 1'b1;
            end
        end
        m_busy = (n_occ > 0);
    endtask

    task automatic do_reset();
        iWr   = '0;
        iRel  = '0;
        iData = '0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]   wr;
        logic [127:0] data;
        logic [3:0]   rel;
        logic [31:0]  seg;
        logic         we;
        logic [1:0]   cur;
        logic         busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] wr, input logic [127:0] data, input logic [3:0] rel,
                                input logic [31:0] seg, input logic we, input logic [1:0] cur,
                                input logic busy);
        vec_t v;
        v.wr = wr; v.data = data; v.rel = rel;
        v.seg = seg; v.we = we; v.cur = cur; v.busy = busy;
        return v;
    endfunction

    localparam logic [31:0] VA = 32'h0A0A_0A0A;
    localparam logic [31:0] VB = 32'h0B0B_0B0B;

    initial begin
        logic [3:0]   r_wr;
        logic [3:0]   r_rel;
        logic [127:0] r_data;

        // Single slot 2, hold, release, idle, write+release collision.
        tbl.push_back(mk(4'b0100, d(2, 32'h1234_5678), 4'b0000, 32'h1234_5678, 1'b1, 2'd2, 1'b1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'b0000, '0, 4'b0000, 32'h1234_5678, 1'b0, 2'd2, 1'b1));
        tbl.push_back(mk(4'b0000, '0, 4'b0100, IDLE, 1'b1, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0000, '0, 4'b0000, IDLE, 1'b0, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0100, d(2, 32'hFFFF_0000), 4'b0100, IDLE, 1'b0, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0000, '0, 4'b0000, IDLE, 1'b0, 2'd2, 1'b0));
        // Simultaneous first writes to slots 0 and 3: slot 0 wins, then rotate 0,3,0.
        tbl.push_back(mk(4'b1001, d(0, VA) | d(3, VB), 4'b0000, VA, 1'b1, 2'd0, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(4'b0000, '0, 4'b0000, VA, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(4'b0000, '0, 4'b0000, VB, 1'b1, 2'd3, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(4'b0000, '0, 4'b0000, VB, 1'b0, 2'd3, 1'b1));
        tbl.push_back(mk(4'b0000, '0, 4'b0000, VA, 1'b1, 2'd0, 1'b1));

        do_reset();
        check("reset_state", outs(), pk(IDLE, 1'b0, 2'd0, 1'b0));

        foreach (tbl[i]) begin
            step_chk($sformatf("table_row%0d", i), tbl[i].wr, tbl[i].data, tbl[i].rel,
                     pk(tbl[i].seg, tbl[i].we, tbl[i].cur, tbl[i].busy));
        end

        // Release shown slot 1 mid-dwell with slots 0 and 3 occupied.
        do_reset();
        step_chk("relmid_w1",   4'b0010, d(1, 32'h11), 4'b0000, pk(32'h11, 1'b1, 2'd1, 1'b1));
        step_chk("relmid_w03",  4'b1001, d(0, 32'h100) | d(3, 32'h33), 4'b0000,
                 pk(32'h11, 1'b0, 2'd1, 1'b1));
        step_chk("relmid_rel",  4'b0000, '0, 4'b0010, pk(32'h33, 1'b1, 2'd3, 1'b1));
        for (int i = 0; i < 3; i++)
            step_chk($sformatf("relmid_hold%0d", i), 4'b0000, '0, 4'b0000,
                     pk(32'h33, 1'b0, 2'd3, 1'b1));
        step_chk("relmid_rot",  4'b0000, '0, 4'b0000, pk(32'h100, 1'b1, 2'd0, 1'b1));

        // Write to shown slot 0 one cycle before expiry, slot 1 occupied.
        do_reset();
        step_chk("wrexp_w0",    4'b0001, d(0, 32'h100), 4'b0000, pk(32'h100, 1'b1, 2'd0, 1'b1));
        step_chk("wrexp_w1",    4'b0010, d(1, 32'h111), 4'b0000, pk(32'h100, 1'b0, 2'd0, 1'b1));
        step_chk("wrexp_idle",  4'b0000, '0, 4'b0000, pk(32'h100, 1'b0, 2'd0, 1'b1));
        step_chk("wrexp_beef",  4'b0001, d(0, 32'hDEAD_BEEF), 4'b0000,
                 pk(32'hDEAD_BEEF, 1'b1, 2'd0, 1'b1));
        step_chk("wrexp_rot",   4'b0000, '0, 4'b0000, pk(32'h111, 1'b1, 2'd1, 1'b1));
        step_chk("wrexp_after", 4'b0000, '0, 4'b0000, pk(32'h111, 1'b0, 2'd1, 1'b1));

        // Asynchronous reset in the middle of SHOW.
        do_reset();
        step_chk("arst_w1",     4'b0010, d(1, 32'h55), 4'b0000, pk(32'h55, 1'b1, 2'd1, 1'b1));
        step_chk("arst_idle",   4'b0000, '0, 4'b0000, pk(32'h55, 1'b0, 2'd1, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_async", outs(), pk(IDLE, 1'b0, 2'd0, 1'b0));
        tick();
        check("arst_hold", outs(), pk(IDLE, 1'b0, 2'd0, 1'b0));
        rst = 1'b0;
        tick();
        check("arst_after", outs(), pk(IDLE, 1'b0, 2'd0, 1'b0));

        // Randomized run against the behavioural model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                r_wr[i]  = ($urandom_range(0, 7) == 0);
                r_rel[i] = ($urandom_range(0, 15) == 0);
            end
            r_data = {$urandom, $urandom, $urandom, $urandom};
            apply(r_wr, r_data, r_rel);
            model_step(r_wr, r_data, r_rel);
            check($sformatf("random_cycle%0d", n), outs(), pk(m_seg, m_we, 2'(m_cur), m_busy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
